gray_wptr_full: RTL and testbench

- Write-side pointer stage for the team's async FIFO.
- Keeps an (ADDR_W+1)-bit binary write pointer and converts it to Gray code for export to the read domain.
- Synchronises the incoming Gray read pointer and produces a registered full flag.
- Sits directly upstream of the pointer synchroniser and consumes the Gray-code conversion that the 4-bit binary-to-Gray stage already provides, generalised to N bits.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray_wptr_full_if.sv | 32 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/gray_wptr_full.sv | 61 ++++++
 tb/tb_gray_wptr_full.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared constants and Gray-code helpers for the async FIFO pointer stages.
package gray_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned PTR_W  = ADDR_W + 1;

    // Binary to reflected-binary Gray: MSB passes, other bits XOR adjacent binary bits.
    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray back to binary; used by the read-side pointer stage.
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
        logic [PTR_W-1:0] bin;
        bin[PTR_W-1] = gray[PTR_W-1];
        for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_wptr_full_if.sv
// Producer-side bundle of the write pointer stage.
interface gray_wptr_full_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W:0]   rptr_gray_async;
    logic [ADDR_W:0]   wptr_gray;
    logic [ADDR_W-1:0] waddr;
    logic              wr_ack;
    logic              full;
    logic              overflow;

    modport master (
        output wr_en,
        output rptr_gray_async,
        input  wptr_gray,
        input  waddr,
        input  wr_ack,
        input  full,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  rptr_gray_async,
        output wptr_gray,
        output waddr,
        output wr_ack,
        output full,
        output overflow
    );
endinterface

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchroniser with synchronous active-high reset.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] rq1_q;
    logic [Width-1:0] rq2_q;

    // Two capture stages; only the second is safe to consume.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rq1_q <= '0;
            rq2_q <= '0;
        end else begin
            rq1_q <= d_i;
            rq2_q <= rq1_q;
        end
    end

    assign q_o = rq2_q;

endmodule

// File: rtl/gray_wptr_full.sv
// Write-side pointer stage: binary/Gray write pointer, synchronised read pointer, full flag.
module gray_wptr_full #(
    parameter int unsigned ADDR_W = gray_pkg::ADDR_W
) (
    input logic              clk,
    input logic              rst,
    gray_wptr_full_if.slave  bus
);

    import gray_pkg::*;

    localparam int unsigned PtrW = ADDR_W + 1;

    logic [PtrW-1:0] wbin_q, wbin_d;
    logic [PtrW-1:0] wgray_q, wgray_d;
    logic [PtrW-1:0] rq2;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;
    logic            inc;

    sync_2ff #(
        .Width (PtrW)
    ) u_rptr_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (bus.rptr_gray_async),
        .q_o   (rq2)
    );

    // Next pointer, Gray image and flags; full compares against read pointer one lap behind.
    always_comb begin
        inc     = bus.wr_en & ~full_q;
        wbin_d  = wbin_q + {{ADDR_W{1'b0}}, inc};
        wgray_d = bin2gray(wbin_d);
        full_d  = (wgray_d == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]});
        ovf_d   = bus.wr_en & full_q;
    end

    // Pointer and flag registers; reset returns to the power-up state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.wptr_gray = wgray_q;
    assign bus.waddr     = wbin_q[ADDR_W-1:0];
    // Masked during reset so no write is acknowledged that reset will discard.
    assign bus.wr_ack    = inc & ~rst;
    assign bus.full      = full_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_gray_wptr_full.sv
// Self-checking bench for gray_wptr_full: occupancy model plus directed literal checks.
module tb_gray_wptr_full;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    gray_wptr_full_if #(.ADDR_W(4)) bus ();

    gray_wptr_full #(
        .ADDR_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray sequence built by reflection, independent of any XOR formula.
    int tab [32];

    function automatic int g2b(input int g);
        for (int i = 0; i < 32; i++) begin
            if (tab[i] == g) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: write count, delayed read pointer, occupancy-based full.
    bit m_valid;
    bit m_acc;
    bit m_full;
    bit m_ovf;
    int m_w;
    int m_rq1;
    int m_rq2;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_acc   = 1'b0;
            m_full  = 1'b0;
            m_ovf   = 1'b0;
            m_w     = 0;
            m_rq1   = 0;
            m_rq2   = 0;
        end else if (m_valid) begin
            bit acc;
            int nb;
            int rd;
            acc    = bus.wr_en && !m_full;
            nb     = (m_w + (acc ? 1 : 0)) % 32;
            rd     = g2b(m_rq2);
            m_ovf  = bus.wr_en && m_full;
            m_full = ((nb - rd + 32) % 32) == 16;
            m_rq2  = m_rq1;
            m_rq1  = int'(bus.rptr_gray_async);
            m_acc  = acc;
            m_w    = nb;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    logic [4:0] prev_gray;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_wptr_gray", 32'(bus.wptr_gray), 32'(tab[m_w]));
            chk("m_waddr", 32'(bus.waddr), 32'(m_w % 16));
            chk("m_full", 32'(bus.full), 32'(m_full));
            chk("m_overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("m_wr_ack", 32'(bus.wr_ack), 32'(bus.wr_en && !m_full && !rst));
            if (m_acc) begin
                chk("one_bit_step", 32'($countones(bus.wptr_gray ^ prev_gray)), 32'd1);
            end
            prev_gray = bus.wptr_gray;
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] pg;
        bit         wrapped;
        n_pass  = 0;
        n_total = 0;
        tab[0]  = 0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                tab[(1 << k) + i] = (1 << k) | tab[(1 << k) - 1 - i];
            end
        end
        chk("tab16", 32'(tab[16]), 32'b11000);
        chk("tab17", 32'(tab[17]), 32'b11001);

        // Reset held two cycles with wr_en high.
        rst                 = 1'b1;
        bus.wr_en           = 1'b1;
        bus.rptr_gray_async = 5'd0;
        edge1();
        edge1();
        chk("rst_wptr_gray", 32'(bus.wptr_gray), 32'd0);
        chk("rst_waddr", 32'(bus.waddr), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
        rst = 1'b0;
        #1;
        chk("ack_after_rst", 32'(bus.wr_ack), 32'd1);

        // Fill 16 entries.
        for (int i = 0; i < 16; i++) begin
            chk("fill_waddr", 32'(bus.waddr), 32'(i));
            chk("fill_ack", 32'(bus.wr_ack), 32'd1);
            edge1();
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_gray", 32'(bus.wptr_gray), 32'b11000);

        // One write while full.
        chk("ovf_ack", 32'(bus.wr_ack), 32'd0);
        edge1();
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        chk("ovf_gray_hold", 32'(bus.wptr_gray), 32'b11000);
        chk("ovf_waddr_hold", 32'(bus.waddr), 32'd0);
        bus.wr_en = 1'b0;
        edge1();
        chk("ovf_clear", 32'(bus.overflow), 32'd0);

        // Release: full drops on the third edge.
        bus.rptr_gray_async = 5'b00001;
        edge1();
        chk("rel_full_e1", 32'(bus.full), 32'd1);
        edge1();
        chk("rel_full_e2", 32'(bus.full), 32'd1);
        edge1();
        chk("rel_full_e3", 32'(bus.full), 32'd0);
        bus.wr_en = 1'b1;
        #1;
        chk("rel_ack", 32'(bus.wr_ack), 32'd1);
        edge1();
        chk("rel_gray", 32'(bus.wptr_gray), 32'b11001);
        bus.wr_en = 1'b0;

        // Wrap: read side trails by four entries.
        bus.rptr_gray_async = 5'(tab[(m_w + 28) % 32]);
        repeat (3) edge1();
        chk("wrap_pre_full", 32'(bus.full), 32'd0);
        wrapped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.wr_en           = 1'b1;
            bus.rptr_gray_async = 5'(tab[(m_w + 28) % 32]);
            pg = bus.wptr_gray;
            edge1();
            if (pg == 5'b10000 && bus.wptr_gray == 5'b00000) wrapped = 1'b1;
            chk("wrap_full", 32'(bus.full), 32'd0);
        end
        chk("wrap_seen", 32'(wrapped), 32'd1);
        chk("wrap_end_gray", 32'(bus.wptr_gray), 32'b10101);

        // Mid-operation reset.
        bus.wr_en           = 1'b0;
        bus.rptr_gray_async = 5'd0;
        rst                 = 1'b1;
        edge1();
        rst       = 1'b0;
        bus.wr_en = 1'b1;
        repeat (7) edge1();
        chk("mid_gray7", 32'(bus.wptr_gray), 32'b00100);
        rst = 1'b1;
        edge1();
        chk("mid_gray", 32'(bus.wptr_gray), 32'd0);
        chk("mid_waddr", 32'(bus.waddr), 32'd0);
        chk("mid_full", 32'(bus.full), 32'd0);
        chk("mid_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("restart_waddr", 32'(bus.waddr), 32'(i));
            edge1();
        end
        bus.wr_en = 1'b0;
        edge1();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
